grf_wb_arbiter: RTL and testbench

Write-side front end of the general register file: merges the in-order pipeline write-back stream with a secondary, out-of-band result producer (bus loads, multi-cycle multiply/divide) onto the GRF's single write port. Pipeline writes always win. Secondary results wait in a small circular buffer, issued on idle write-port cycles. The block also exports a read-side hazard query so the ID stage stalls on registers whose value is still buffered.

---
 rtl/grf_wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/grf_wb_arbiter.sv | 110 +++++++++++
 tb/tb_grf_wb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_pkg.sv
// GRF write-side shared types: register/data widths and the buffered write-back entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package grf_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // One pending register write; a3 == 0 means "no write" (killed or discarded).
  typedef struct packed {
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending secondary write-backs with in-place WAW kill and age-ordered hit vector.
// Latency: push visible at head one cycle after the push edge; pop takes effect at the edge.
// Backpressure: caller must not push when full or pop when empty; full is exported through count.
//
// Ports: clk, reset (async active-low); push/push_entry, pop; kill_a3 clears matching
// buffered a3 fields at the edge; q_a1/q_a2 query addresses; head = oldest entry;
// count = occupied slots; hit[i] = i-th oldest occupied entry is live and matches a query.
module wb_fifo
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic [ADDR_W-1:0] kill_a3,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output wb_entry_t         head,
  output logic [CW-1:0]     count,
  output logic [DEPTH-1:0]  hit
);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Kill first; a push into the same slot (only possible into a free slot)
      // overrides it, and the caller has already applied the kill to push_entry.
      if (kill_a3 != '0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].a3 == kill_a3) mem[i].a3 <= '0;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

  // Age-ordered so bit 0 is always the head, which lets the caller mask the draining entry.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt) && (mem[rd_ptr + PW'(i)].a3 != '0) &&
          ((mem[rd_ptr + PW'(i)].a3 == q_a1) || (mem[rd_ptr + PW'(i)].a3 == q_a2)))
        hit[i] = 1'b1;
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Merges pipeline WB with buffered secondary results onto the single GRF write port; exports read hazard.
// Latency: pipeline write 0 cycles; secondary result earliest one cycle after accept, on an idle port cycle.
// Backpressure: aux_ready = not full (registered state only); drain_req asks for a WB bubble when starved.
//
// Ports: clk, reset (async active-low); pipe_a3/pipe_wd pipeline WB; aux_valid/aux_ready/
// aux_a3/aux_wd secondary producer; grf_a3/grf_wd GRF write port; q_a1/q_a2 -> q_stall
// read hazard; drain_req bubble request; count buffered entries.
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pipe_a3,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_a3,
  input  logic [DATA_W-1:0] aux_wd,
  output logic [ADDR_W-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_stall,
  output logic              drain_req,
  output logic [CW-1:0]     count
);

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic [DEPTH-1:0]  hit;
  logic [DEPTH-1:0]  drain_mask;
  logic              accept;
  logic              push;
  logic              pop;
  logic [SW-1:0]     starve;

  // Ready depends only on registered occupancy; full blocks pushes even on a pop cycle.
  assign aux_ready = reset && (count != CW'(DEPTH));
  assign accept    = aux_valid && aux_ready;
  // A zero destination completes the handshake without taking a slot.
  assign push      = accept && (aux_a3 != '0);
  assign pop       = reset && (pipe_a3 == '0) && (count != '0);

  // Same-cycle pipeline write to the same register is younger: store the result as a no-write.
  always_comb begin
    push_entry.wd = aux_wd;
    push_entry.a3 = (aux_a3 == pipe_a3) ? '0 : aux_a3;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_a3    (pipe_a3),
    .q_a1       (q_a1),
    .q_a2       (q_a2),
    .head       (head),
    .count      (count),
    .hit        (hit)
  );

  always_comb begin
    grf_a3 = '0;
    grf_wd = '0;
    if (reset) begin
      if (pipe_a3 != '0) begin
        grf_a3 = pipe_a3;
        grf_wd = pipe_wd;
      end else if (count != '0) begin
        grf_a3 = head.a3;
        grf_wd = head.wd;
      end
    end
  end

  // The draining head is forwarded by the GRF bypass, so it never stalls. Entries being
  // killed this cycle are still live in hit[] and therefore stall.
  assign drain_mask = {{(DEPTH-1){1'b0}}, pop};

  always_comb begin
    q_stall = 1'b0;
    if (reset) begin
      if ((hit & ~drain_mask) != '0) q_stall = 1'b1;
      if (push && (push_entry.a3 != '0) &&
          ((push_entry.a3 == q_a1) || (push_entry.a3 == q_a2)))
        q_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if ((count == '0) || pop) begin
      starve <= '0;
    end else if (starve != SW'(STARVE_MAX)) begin
      // Non-empty and not draining means the pipeline held the port this cycle.
      starve <= starve + 1'b1;
    end
  end

  assign drain_req = reset && (starve == SW'(STARVE_MAX));

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with a register-file model fed from the GRF write port.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later, state checked next negedge.
// Backpressure: bench honours aux_ready through the DUT's own accept logic.
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_a3;
  logic [31:0] aux_wd;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_stall;
  logic        drain_req;
  logic [1:0]  count;

  logic [31:0] rf [32];
  int          passed;
  int          total;

  grf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_a3   (pipe_a3),
    .pipe_wd   (pipe_wd),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_a3    (aux_a3),
    .aux_wd    (aux_wd),
    .grf_a3    (grf_a3),
    .grf_wd    (grf_wd),
    .q_a1      (q_a1),
    .q_a2      (q_a2),
    .q_stall   (q_stall),
    .drain_req (drain_req),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model; cleared together with the arbiter.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (grf_a3 != '0) begin
      rf[grf_a3] <= grf_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    pipe_a3   = '0;
    pipe_wd   = '0;
    aux_valid = 1'b0;
    aux_a3    = '0;
    aux_wd    = '0;
    q_a1      = '0;
    q_a2      = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    idle_inputs();

    // Reset state, with a pipeline write attempted during reset.
    next_cycle();
    pipe_a3 = 5'd3; pipe_wd = 32'h1234;
    #1;
    check("rst_aux_ready", aux_ready, 0);
    check("rst_count",     count, 0);
    check("rst_grf_a3",    grf_a3, 0);
    check("rst_grf_wd",    grf_wd, 0);
    check("rst_drain_req", drain_req, 0);
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rel_aux_ready", aux_ready, 1);

    // Idle pipe: accept at edge k, drain in cycle k+1.
    next_cycle();
    aux_valid = 1'b1; aux_a3 = 5'd8; aux_wd = 32'hDEADBEEF; q_a1 = 5'd8;
    #1;
    check("idle_stall_accept", q_stall, 1);
    next_cycle();
    aux_valid = 1'b0;
    #1;
    check("idle_count1",      count, 1);
    check("idle_grf_a3",      grf_a3, 8);
    check("idle_grf_wd",      grf_wd, 32'hDEADBEEF);
    check("idle_stall_drain", q_stall, 0);
    next_cycle();
    #1;
    check("idle_rf8",    rf[8], 32'hDEADBEEF);
    check("idle_count0", count, 0);

    // Fill with pipeline holding the port every cycle.
    next_cycle();
    idle_inputs();
    pipe_a3 = 5'd3; pipe_wd = 32'h33;
    aux_valid = 1'b1; aux_a3 = 5'd9; aux_wd = 32'h99;
    next_cycle();
    aux_a3 = 5'd10; aux_wd = 32'h1010; q_a1 = 5'd9;
    #1;
    check("fill_stall_buffered", q_stall, 1);
    check("fill_grf_pipe",       grf_a3, 3);
    next_cycle();
    aux_a3 = 5'd11; aux_wd = 32'h1111;
    #1;
    check("fill_ready_full", aux_ready, 0);
    check("fill_count2",     count, 2);
    next_cycle();
    next_cycle();
    #1;
    check("fill_drain_req_early", drain_req, 0);
    next_cycle();
    aux_valid = 1'b0;
    #1;
    check("fill_drain_req", drain_req, 1);
    check("fill_no_accept_full", count, 2);
    check("fill_rf3", rf[3], 32'h33);
    pipe_a3 = '0;
    #1;
    check("bubble_grf_a3", grf_a3, 9);
    check("bubble_grf_wd", grf_wd, 32'h99);
    next_cycle();
    pipe_a3 = '0; q_a1 = '0;
    #1;
    check("bubble_ready",     aux_ready, 1);
    check("bubble_drain_off", drain_req, 0);
    check("bubble_count1",    count, 1);
    check("bubble_rf9",       rf[9], 32'h99);
    next_cycle();
    #1;
    check("fill_count0", count, 0);
    check("fill_rf10",   rf[10], 32'h1010);

    // WAW kill of a buffered entry.
    idle_inputs();
    aux_valid = 1'b1; aux_a3 = 5'd5; aux_wd = 32'h11;
    next_cycle();
    idle_inputs();
    pipe_a3 = 5'd5; pipe_wd = 32'h22; q_a1 = 5'd5;
    #1;
    check("waw_stall_kill_cycle", q_stall, 1);
    next_cycle();
    pipe_a3 = '0;
    #1;
    check("waw_stall_after", q_stall, 0);
    check("waw_drain_nowrite", grf_a3, 0);
    check("waw_count1", count, 1);
    next_cycle();
    #1;
    check("waw_count0", count, 0);
    check("waw_rf5",    rf[5], 32'h22);

    // Same-cycle kill.
    idle_inputs();
    aux_valid = 1'b1; aux_a3 = 5'd7; aux_wd = 32'hAA;
    pipe_a3 = 5'd7; pipe_wd = 32'hBB; q_a2 = 5'd7;
    #1;
    check("same_stall", q_stall, 0);
    next_cycle();
    idle_inputs();
    #1;
    check("same_count1",   count, 1);
    check("same_drain_a3", grf_a3, 0);
    next_cycle();
    #1;
    check("same_count0", count, 0);
    check("same_rf7",    rf[7], 32'hBB);

    // Zero-destination push is consumed without storage.
    aux_valid = 1'b1; aux_a3 = 5'd0; aux_wd = 32'h55;
    #1;
    check("zero_ready", aux_ready, 1);
    next_cycle();
    idle_inputs();
    #1;
    check("zero_count",  count, 0);
    check("zero_grf_a3", grf_a3, 0);

    // Reset mid-drain with two entries buffered.
    pipe_a3 = 5'd4; pipe_wd = 32'h44;
    aux_valid = 1'b1; aux_a3 = 5'd12; aux_wd = 32'hC;
    next_cycle();
    aux_a3 = 5'd13; aux_wd = 32'hD;
    next_cycle();
    idle_inputs();
    q_a1 = 5'd13;
    #1;
    check("mid_count2", count, 2);
    check("mid_grf_a3", grf_a3, 12);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_grf_a3",  grf_a3, 0);
    check("mid_rst_grf_wd",  grf_wd, 0);
    check("mid_rst_count",   count, 0);
    check("mid_rst_stall",   q_stall, 0);
    check("mid_rst_ready",   aux_ready, 0);
    next_cycle();
    reset = 1'b1;
    #1;
    check("post_count",  count, 0);
    check("post_ready",  aux_ready, 1);
    check("post_grf_a3", grf_a3, 0);
    next_cycle();
    #1;
    check("post_rf12", rf[12], 0);
    check("post_rf13", rf[13], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
